// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage sitting behind register_file.
//
// Purpose
//   Takes the two read-port operands plus an opcode and destination address,
//   computes a result and offers it (with write address and write strobe) to the
//   register file write port under a valid/ready handshake.
//   ADD/SUB/AND/OR/XOR/SLT/SLL/SRL/SRA complete with one cycle of latency.
//   MUL is an iterative LSB-first shift-add that takes WIDTH cycles.
//
// Optional feature
//   Define ALU_EXEC_DIVU_EN to add op 0xA (DIVU): unsigned restoring division,
//   WIDTH cycles, quotient only. A zero divisor gives an all-ones quotient.
//   Without the macro, op 0xA is treated as illegal and no divider is built.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   in_valid/ready  input handshake; op, opa, opb, rd_addr sampled on accept
//   out_valid/ready output handshake; result, wb_addr, zero held until taken
//   wb_we           write strobe: out_valid && out_ready && op was legal
//   busy            iterative operation in progress
module alu_exec_stage #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  opa,
    input  logic [WIDTH-1:0]  opb,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_we,
    output logic              zero,
    output logic              busy
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_MUL  = 4'h9;
`ifdef ALU_EXEC_DIVU_EN
    localparam logic [3:0] OP_DIVU = 4'hA;
`endif

    typedef enum logic [1:0] {
        IDLE,
        MUL
`ifdef ALU_EXEC_DIVU_EN
        , DIV
`endif
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt_p0;
    logic [WIDTH-1:0]  acc_p0;
    logic [WIDTH-1:0]  mcand_p0;
    logic [WIDTH-1:0]  mplier_p0;
    logic [WIDTH-1:0]  result_p1;
    logic [ADDR_W-1:0] wb_addr_p1;
    logic              vld_p1;
    logic              legal_p1;
    logic              rdy_en;

    logic              accept;
    logic              cnt_last;
    logic              long_op;
    logic [WIDTH:0]    single_res;
    logic [WIDTH-1:0]  mul_sum;

    // Single-cycle operations. Returns {legal, value}; illegal codes give 0.
    function automatic logic [WIDTH:0] alu_single(input logic [3:0]       f_op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [4:0]              sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[4:0];
        case (f_op)
            OP_ADD:  return {1'b1, a + b};
            OP_SUB:  return {1'b1, a - b};
            OP_AND:  return {1'b1, a & b};
            OP_OR:   return {1'b1, a | b};
            OP_XOR:  return {1'b1, a ^ b};
            OP_SLT:  return {1'b1, {(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLL:  return {1'b1, a << sh};
            OP_SRL:  return {1'b1, a >> sh};
            OP_SRA:  return {1'b1, $unsigned(sa >>> sh)};
            default: return {1'b0, {WIDTH{1'b0}}};
        endcase
    endfunction

    assign accept     = in_valid && in_ready;
    assign cnt_last   = (cnt_p0 == CNT_LAST);
    assign single_res = alu_single(op, opa, opb);
    assign mul_sum    = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);

`ifdef ALU_EXEC_DIVU_EN
    // Divider reuses the multiplier registers: acc = partial remainder,
    // mplier = dividend shifting out MSB-first while quotient bits shift in,
    // mcand = divisor. A zero divisor always "fits", giving all-ones.
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign rem_sh  = {acc_p0, mplier_p0[WIDTH-1]};
    assign div_ge  = (rem_sh >= {1'b0, mcand_p0});
    assign rem_nxt = div_ge ? (rem_sh[WIDTH-1:0] - mcand_p0) : rem_sh[WIDTH-1:0];
    assign quo_nxt = {mplier_p0[WIDTH-2:0], div_ge};
    assign long_op = (op == OP_MUL) || (op == OP_DIVU);
`else
    assign long_op = (op == OP_MUL);
`endif

    // ---- control: state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && op == OP_MUL) state_nxt = MUL;
`ifdef ALU_EXEC_DIVU_EN
                if (accept && op == OP_DIVU) state_nxt = DIV;
`endif
            end
            MUL:     if (cnt_last) state_nxt = IDLE;
`ifdef ALU_EXEC_DIVU_EN
            DIV:     if (cnt_last) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // ---- p0: iteration registers / p1: output registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en     <= 1'b0;
            cnt_p0     <= '0;
            acc_p0     <= '0;
            mcand_p0   <= '0;
            mplier_p0  <= '0;
            result_p1  <= '0;
            wb_addr_p1 <= '0;
            vld_p1     <= 1'b0;
            legal_p1   <= 1'b0;
        end else begin
            // Keeps in_ready low for the first cycle after reset release.
            rdy_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wb_addr_p1 <= rd_addr;
                        cnt_p0     <= '0;
                        acc_p0     <= '0;
                        if (long_op) begin
                            // Any draining result was consumed on this edge.
                            vld_p1 <= 1'b0;
`ifdef ALU_EXEC_DIVU_EN
                            mcand_p0  <= (op == OP_DIVU) ? opb : opa;
                            mplier_p0 <= (op == OP_DIVU) ? opa : opb;
`else
                            mcand_p0  <= opa;
                            mplier_p0 <= opb;
`endif
                        end else begin
                            vld_p1    <= 1'b1;
                            legal_p1  <= single_res[WIDTH];
                            result_p1 <= single_res[WIDTH-1:0];
                        end
                    end else if (vld_p1 && out_ready) begin
                        vld_p1 <= 1'b0;
                    end
                end
                MUL: begin
                    acc_p0    <= mul_sum;
                    mcand_p0  <= mcand_p0 << 1;
                    mplier_p0 <= mplier_p0 >> 1;
                    cnt_p0    <= cnt_p0 + CNT_W'(1);
                    if (cnt_last) begin
                        result_p1 <= mul_sum;
                        legal_p1  <= 1'b1;
                        vld_p1    <= 1'b1;
                    end
                end
`ifdef ALU_EXEC_DIVU_EN
                DIV: begin
                    acc_p0    <= rem_nxt;
                    mplier_p0 <= quo_nxt;
                    cnt_p0    <= cnt_p0 + CNT_W'(1);
                    if (cnt_last) begin
                        result_p1 <= quo_nxt;
                        legal_p1  <= 1'b1;
                        vld_p1    <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = rdy_en && (state == IDLE) && (!vld_p1 || out_ready);
    assign out_valid = vld_p1;
    assign result    = result_p1;
    assign wb_addr   = wb_addr_p1;
    assign zero      = (result_p1 == '0);
    assign wb_we     = vld_p1 && out_ready && legal_p1;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: reference model plus per-cycle compare, a set of
// hand-computed directed cases, then randomized traffic with backpressure.
// Honours ALU_EXEC_DIVU_EN the same way the design does.
module tb_alu_exec_stage;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [3:0]    op        = '0;
    logic [W-1:0]  opa       = '0;
    logic [W-1:0]  opb       = '0;
    logic [AW-1:0] rd_addr   = '0;
    logic          in_ready, out_valid, wb_we, zero, busy;
    logic [W-1:0]  result;
    logic [AW-1:0] wb_addr;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_stage #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .opa(opa), .opb(opb), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .wb_addr(wb_addr), .wb_we(wb_we), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic checkb(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {legal, value} straight from the opcode table.
    function automatic logic [W:0] ref_op(input logic [3:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [63:0] prod;
        case (o)
            4'h0: return {1'b1, a + b};
            4'h1: return {1'b1, a - b};
            4'h2: return {1'b1, a & b};
            4'h3: return {1'b1, a | b};
            4'h4: return {1'b1, a ^ b};
            4'h5: return {1'b1, 31'd0, ($signed(a) < $signed(b))};
            4'h6: return {1'b1, a << b[4:0]};
            4'h7: return {1'b1, a >> b[4:0]};
            4'h8: return {1'b1, $unsigned($signed(a) >>> b[4:0])};
            4'h9: begin
                prod = {32'd0, a} * {32'd0, b};
                return {1'b1, prod[W-1:0]};
            end
`ifdef ALU_EXEC_DIVU_EN
            4'hA: return {1'b1, (b == 0) ? {W{1'b1}} : a / b};
`endif
            default: return {1'b0, {W{1'b0}}};
        endcase
    endfunction

    function automatic logic is_long(input logic [3:0] o);
`ifdef ALU_EXEC_DIVU_EN
        return (o == 4'h9) || (o == 4'hA);
`else
        return (o == 4'h9);
`endif
    endfunction

    logic          m_run = 1'b0, m_valid = 1'b0, m_legal = 1'b0;
    logic [W-1:0]  m_res = '0, m_pend = '0;
    logic [AW-1:0] m_addr = '0, m_pend_addr = '0;
    int            m_busy = 0;
    logic [W:0]    ref_now;

    assign ref_now = ref_op(op, opa, opb);

    function automatic logic exp_ready();
        return m_run && (m_busy == 0) && (!m_valid || out_ready);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run   <= 1'b0;
            m_valid <= 1'b0;
            m_legal <= 1'b0;
            m_busy  <= 0;
            m_res   <= '0;
            m_addr  <= '0;
        end else begin
            m_run <= 1'b1;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_valid <= 1'b1;
                    m_res   <= m_pend;
                    m_addr  <= m_pend_addr;
                    m_legal <= 1'b1;
                end
            end else if (in_valid && exp_ready()) begin
                if (is_long(op)) begin
                    m_busy      <= W;
                    m_valid     <= 1'b0;
                    m_pend      <= ref_now[W-1:0];
                    m_pend_addr <= rd_addr;
                end else begin
                    m_valid <= 1'b1;
                    m_res   <= ref_now[W-1:0];
                    m_legal <= ref_now[W];
                    m_addr  <= rd_addr;
                end
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle compare, mid-cycle so outputs and inputs are settled.
    always @(negedge clk) begin
        checkb("out_valid", out_valid, m_valid);
        checkb("in_ready", in_ready, exp_ready());
        checkb("busy", busy, m_busy > 0);
        checkb("wb_we", wb_we, m_valid && out_ready && m_legal);
        if (m_valid) begin
            check("result", result, m_res);
            check("wb_addr", W'(wb_addr), W'(m_addr));
            checkb("zero", zero, m_res == '0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic drive(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] ad);
        in_valid = 1'b1;
        op       = o;
        opa      = a;
        opb      = b;
        rd_addr  = ad;
    endtask

    // Returns just after the accepting edge; c = cycles spent with in_ready low.
    task automatic wait_accept(output int c);
        c = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            c++;
            if (c > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: waited %0d cycles, required <= 200", c);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic single(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [AW-1:0] ad, input logic [W-1:0] exp_r,
                          input logic exp_we, input string nm);
        int c;
        drive(o, a, b, ad);
        wait_accept(c);
        in_valid = 1'b0;
        checkb({nm, "_valid"}, out_valid, 1'b1);
        check({nm, "_result"}, result, exp_r);
        check({nm, "_addr"}, W'(wb_addr), W'(ad));
        checkb({nm, "_we"}, wb_we, exp_we);
        checkb({nm, "_zero"}, zero, exp_r == '0);
    endtask

    task automatic long_run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [AW-1:0] ad, input logic [W-1:0] exp_r, input string nm);
        int c, lat;
        drive(o, a, b, ad);
        wait_accept(c);
        in_valid = 1'b0;
        wait_valid(lat);
        check({nm, "_latency"}, lat, 32);
        check({nm, "_result"}, result, exp_r);
        check({nm, "_addr"}, W'(wb_addr), W'(ad));
        checkb({nm, "_we"}, wb_we, 1'b1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int  c;
        logic seen;
        logic [3:0] o;

        // Power-on reset state.
        repeat (2) @(posedge clk);
        #1;
        checkb("por_valid", out_valid, 1'b0);
        check("por_result", result, '0);
        check("por_addr", W'(wb_addr), '0);
        checkb("por_we", wb_we, 1'b0);
        checkb("por_zero", zero, 1'b1);
        checkb("por_busy", busy, 1'b0);
        checkb("por_ready", in_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkb("ready_after_reset", in_ready, 1'b1);

        // Single-cycle operations with literal expectations.
        single(4'h0, 32'h0000_0005, 32'h0000_0003, 5'd7, 32'h0000_0008, 1'b1, "add");
        single(4'h1, 32'h0000_0003, 32'h0000_0005, 5'd8, 32'hFFFF_FFFE, 1'b1, "sub");
        single(4'h5, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9, 32'h0000_0001, 1'b1, "slt");
        single(4'h8, 32'h8000_0000, 32'h0000_0021, 5'd10, 32'hC000_0000, 1'b1, "sra");
        single(4'h7, 32'h8000_0000, 32'h0000_0021, 5'd11, 32'h4000_0000, 1'b1, "srl");
        single(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 32'h0000_0000, 1'b0, "illegal_f");
`ifdef ALU_EXEC_DIVU_EN
        long_run(4'hA, 32'd100, 32'd7, 5'd13, 32'd14, "divu");
        long_run(4'hA, 32'hDEAD_BEEF, 32'd0, 5'd14, 32'hFFFF_FFFF, "divu_zero");
`else
        single(4'hA, 32'd100, 32'd7, 5'd13, 32'h0000_0000, 1'b0, "divu_off");
`endif

        // Multiply latency and result.
        long_run(4'h9, 32'h0001_0003, 32'h0000_0005, 5'd15, 32'h0005_000F, "mul");

        // Second request held through a multiply is accepted only afterwards.
        drive(4'h9, 32'd7, 32'd6, 5'd1);
        wait_accept(c);
        drive(4'h0, 32'd10, 32'd20, 5'd2);
        wait_accept(c);
        in_valid = 1'b0;
        check("mul_hold_wait", c, 32);
        check("mul_hold_next_result", result, 32'd30);
        check("mul_hold_next_addr", W'(wb_addr), 32'd2);

        // Backpressure, then back-to-back accept on release.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(4'h0, 32'h0000_0100, 32'h0000_0023, 5'd9);
        wait_accept(c);
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_result", result, 32'h0000_0123);
            check("bp_hold_addr", W'(wb_addr), 32'd9);
            checkb("bp_hold_we", wb_we, 1'b0);
            checkb("bp_hold_ready", in_ready, 1'b0);
            checkb("bp_hold_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(4'h4, 32'h0000_F0F0, 32'h0000_0FF0, 5'd10);
        @(negedge clk);
        checkb("bp_release_ready", in_ready, 1'b1);
        checkb("bp_release_we", wb_we, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkb("b2b_valid", out_valid, 1'b1);
        check("b2b_result", result, 32'h0000_FF00);
        check("b2b_addr", W'(wb_addr), 32'd10);

        // Asynchronous reset while a result is being offered.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(4'h0, 32'd1, 32'd1, 5'd4);
        wait_accept(c);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checkb("rst_valid", out_valid, 1'b0);
        check("rst_result", result, '0);
        check("rst_addr", W'(wb_addr), '0);
        checkb("rst_we", wb_we, 1'b0);
        checkb("rst_zero", zero, 1'b1);
        checkb("rst_busy", busy, 1'b0);
        checkb("rst_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        checkb("rst_hold_ready", in_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkb("rst_release_ready", in_ready, 1'b1);

        // Reset in the middle of a multiply aborts it.
        drive(4'h9, 32'h0000_1234, 32'h0000_5678, 5'd3);
        wait_accept(c);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkb("abort_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checkb("abort_no_result", seen, 1'b0);

        // Randomized traffic, checked by the per-cycle compare.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            o = 4'($urandom_range(0, 15));
            if (o == 4'h9 && $urandom_range(0, 3) != 0) o = 4'($urandom_range(0, 8));
            op        = o;
            opa       = pick();
            opb       = pick();
            rd_addr   = AW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
